// File: rtl/sqrt_oddsub_if.sv
// Start/busy/done handshake bundle for the odd-subtraction square-root unit.
// The requester drives the master side and the root unit implements the slave side.
`timescale 1ns/1ps
interface sqrt_oddsub_if #(
  parameter int unsigned W = 32
) ();
  logic             start;
  logic [W-1:0]     a;
  logic             busy;
  logic             done;
  logic [W/2-1:0]   root;
  logic [W/2:0]     rem;

  modport master (
    output start,
    output a,
    input  busy,
    input  done,
    input  root,
    input  rem
  );

  modport slave (
    input  start,
    input  a,
    output busy,
    output done,
    output root,
    output rem
  );
endinterface

// File: rtl/sqrt_oddsub.sv
// Integer square root by subtracting successive odd numbers 1, 3, 5, ... from the operand.
// The result is root = number of successful subtractions and rem = what is left over.
`timescale 1ns/1ps
module sqrt_oddsub #(
  parameter int unsigned W = 32
) (
  input  logic              clk,
  input  logic              rst,
  sqrt_oddsub_if.slave      bus
);
  localparam int unsigned HW = W / 2;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    r_q, r_d;
  logic [HW:0]     o_q, o_d;
  logic [HW-1:0]   c_q, c_d;
  logic [HW-1:0]   root_q, root_d;
  logic [HW:0]     rem_q, rem_d;
  logic            done_q, done_d;

  logic [W-1:0]    o_ext;
  logic            can_sub;

  assign o_ext   = W'(o_q);
  assign can_sub = (r_q >= o_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      o_q     <= '0;
      c_q     <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      o_q     <= o_d;
      c_q     <= c_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    o_d     = o_q;
    c_d     = c_q;
    root_d  = root_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          r_d     = bus.a;
          o_d     = (HW + 1)'(1);
          c_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (can_sub) begin
          r_d = r_q - o_ext;
          o_d = o_q + (HW + 1)'(2);
          c_d = c_q + HW'(1);
        end else begin
          // Residue is now below the odd term (<= 2*root+1), so it fits in HW+1 bits.
          root_d  = c_q;
          rem_d   = r_q[HW:0];
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;
  assign bus.root = root_q;
  assign bus.rem  = rem_q;

  a_done_not_busy: assert property (@(posedge clk) disable iff (rst) done_q |-> !bus.busy);
  a_odd_term:      assert property (@(posedge clk) disable iff (rst)
                                    (state_q == StRun) |-> o_q[0]);
  a_rem_range:     assert property (@(posedge clk) disable iff (rst)
                                    done_q |-> (rem_q <= {root_q, 1'b0}));
endmodule

// File: tb/tb_sqrt_oddsub.sv
// Randomised self-checking bench for sqrt_oddsub against a plain-arithmetic root model.
`timescale 1ns/1ps
module tb_sqrt_oddsub;
  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  longint exp_root;
  longint exp_rem;

  sqrt_oddsub_if #(.W(W)) bus ();

  sqrt_oddsub #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Largest r with r*r <= a, found by binary search on 64-bit arithmetic.
  function automatic void ref_sqrt(input longint a, output longint root, output longint rem);
    longint lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= a) lo = mid;
      else hi = mid;
    end
    root = lo;
    rem  = a - lo * lo;
  endfunction

  // Call #1 after an edge; returns #1 after the edge that shows done.
  task automatic run_op(input logic [31:0] av, input bit poke, input logic [31:0] poke_a);
    longint er, em;
    int lat, busy_n;
    bit seen;
    ref_sqrt(longint'(av), er, em);
    bus.start = 1'b1;
    bus.a     = av;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    check("busy_after_accept", bus.busy, 1);
    busy_n = 1;
    lat    = 0;
    seen   = 1'b0;
    while (!seen && lat <= er + 5) begin
      if (poke && lat == 1) begin
        bus.start = 1'b1;
        bus.a     = poke_a;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) busy_n++;
        check("root_held", bus.root, exp_root);
        check("rem_held", bus.rem, exp_rem);
      end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("latency", lat, er + 1);
      check("busy_cycles", busy_n, er + 1);
      check("root", bus.root, er);
      check("rem", bus.rem, em);
      check("busy_at_done", bus.busy, 0);
    end
    exp_root = er;
    exp_rem  = em;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_root  = 0;
    exp_rem   = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_root", bus.root, 0);
    check("rst_rem", bus.rem, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);
      check("idle_root", bus.root, 0);
      check("idle_rem", bus.rem, 0);
    end

    run_op(32'd0, 1'b0, 32'd0);
    run_op(32'd10, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", bus.done, 0);
    check("root_after_done", bus.root, 3);
    run_op(32'd100, 1'b0, 32'd0);
    run_op(32'hFFFF_FFFF, 1'b0, 32'd0);

    // Squares back to back, each started in the done cycle of the previous one.
    for (int k = 1; k <= 40; k++) begin
      run_op(32'(k * k), (k >= 2), 32'($urandom_range(0, 5000000)));
    end

    // Boundaries around perfect squares plus random operands.
    for (int i = 0; i < 10; i++) begin
      int unsigned k;
      k = $urandom_range(1, 300);
      run_op(32'(k * k - 1), 1'b0, 32'd0);
    end
    for (int i = 0; i < 25; i++) begin
      run_op(32'($urandom_range(0, 70000)), $urandom_range(0, 1) == 1,
             32'($urandom_range(0, 70000)));
    end
    run_op(32'd10, 1'b0, 32'd0);

    // Abort mid-run with reset between edges.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 32'd1000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_root", bus.root, 0);
    check("abort_rem", bus.rem, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_root = 0;
    exp_rem  = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      check("no_done_after_abort", bus.done, 0);
      check("no_busy_after_abort", bus.busy, 0);
    end
    run_op(32'd1000, 1'b0, 32'd0);
    check("final_root_1000", bus.root, 31);
    check("final_rem_1000", bus.rem, 39);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sqrt_oddsub.md
# sqrt_oddsub

Sequential integer square-root unit that undoes the odd-number accumulator. That accumulator builds k² by summing 1, 3, 5, …; this block takes a square (or any value) and subtracts successive odd numbers until it can no longer do so. It returns the integer root and the remainder through a start/busy/done handshake. It sits downstream of the accumulator and checks or decodes its output.

## Interface
- W, default 32: operand width; must be even. Root width is W/2; remainder and odd-term width is W/2+1.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high; clears all state and outputs.
- start  input  1  request; sampled only when busy=0.
- a  input  W  operand; captured on the accepting edge and ignored afterwards.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when root/rem are updated.
- root  output  W/2  floor(sqrt(a)) of the last completed operation.
- rem  output  W/2+1  a − root² of the last completed operation; range 0..2·root.

## Operation
- Internal registers: residue r (W bits), odd term o (W/2+1 bits), count c (W/2 bits), state.
- State machine:
  - Two states, IDLE and RUN.
  - busy = (state == RUN), decoded from the state register.
- IDLE with start=1 on an edge:
  - r ← a, o ← 1, c ← 0, state ← RUN.
- RUN, on each edge:
  - If r ≥ o (o zero-extended to W bits): r ← r − o, o ← o + 2, c ← c + 1, stay in RUN.
  - Otherwise: root ← c, rem ← r[W/2:0], done ← 1, state ← IDLE.
- done is registered. It is cleared on every edge where the completion condition is false.
- root and rem hold their value until the next completion. They do not change while an operation is running.
- start while busy=1 is ignored. It is not queued.
- start in the cycle done=1 is accepted, because busy is already 0. This gives back-to-back operations with no idle cycle.
- Widths never overflow:
  - Maximum c is 2^(W/2)−1.
  - Maximum o tested is 2^(W/2+1)−1, which fits in W/2+1 bits.
  - o+2 is only written after a successful subtraction, so it cannot wrap.
- Reset asserted mid-operation:
  - Aborts the operation immediately.
  - No done pulse is produced.
  - root, rem and state return to reset values.

## Timing
- Reset values: busy=0, done=0, root=0, rem=0, state=IDLE, r=0, o=0, c=0.
- Accepting edge E0: busy=1 after E0.
- Compare edges: E1 … E(root+1). The failing compare occurs at E(root+1).
- After E(root+1): done=1 for exactly one cycle, root/rem valid, busy=0.
- Latency from start edge to done = root(a)+1 cycles:
  - minimum 1 cycle (a=0);
  - maximum 2^(W/2) cycles (a = 2^W−1).
- No combinational path from start or a to any output.

## Test plan
- Reset, then hold start=0 for 5 cycles → busy=0, done=0, root=0, rem=0 throughout.
- start with a=0 → done exactly 1 cycle after the start edge; root=0, rem=0.
- start with a=10 → done 4 cycles after start; root=3, rem=1. Then a=100 → root=10, rem=0, done at 11 cycles.
- start with a=0xFFFFFFFF → done after 65536 cycles; root=65535, rem=131070; busy high for exactly 65536 cycles.
- Feed squares from the accumulator (1, 4, 9, … k²), asserting start in each done cycle → each result is root=k, rem=0, with no idle cycle between operations. start pulsed mid-run with a different a → ignored; the result matches the first operand.
- a=1000 started, rst asserted at cycle 5 (between edges) → busy, done, root and rem drop to 0 immediately and no done follows. A subsequent a=1000 → root=31, rem=39.
